change_dispenser: RTL

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_pkg.sv | 26 ++
 rtl/coin_inventory.sv | 20 ++
 rtl/change_dispenser.sv | 117 +++++++++++
 3 files changed

// File: rtl/change_pkg.sv
// change_pkg: amount encodings, FSM states, fault codes and coin planning for the change dispenser
package change_pkg;
    typedef enum logic [1:0] {AMT_0 = 2'b00, AMT_5 = 2'b01, AMT_10 = 2'b10, AMT_15 = 2'b11} amt_e;
    typedef enum logic [2:0] {IDLE, PLAN, EJECT, WAIT, DONE, FAULT} state_e;
    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b01;
    localparam logic [1:0] FAULT_NOCOIN  = 2'b10;
    typedef struct packed {
        logic       ok;
        logic       n10;
        logic [1:0] n5;
    } plan_t;
    // Prefer a 10rs coin when stocked; avail5 is the 5rs stock clamped to 3
    function automatic plan_t make_plan(input amt_e amt, input logic has10, input logic [1:0] avail5);
        plan_t p;
        p = '0;
        case (amt)
            AMT_0:  p = plan_t'{1'b1, 1'b0, 2'd0};
            AMT_5:  p = plan_t'{avail5 != 2'd0, 1'b0, 2'd1};
            AMT_10: p = has10 ? plan_t'{1'b1, 1'b1, 2'd0} : plan_t'{avail5 >= 2'd2, 1'b0, 2'd2};
            AMT_15: p = (has10 && avail5 != 2'd0) ? plan_t'{1'b1, 1'b1, 2'd1}
                                                  : plan_t'{avail5 == 2'd3, 1'b0, 2'd3};
        endcase
        return p;
    endfunction
endpackage

// File: rtl/coin_inventory.sv
// coin_inventory: per-hopper coin count with saturating refill and floor-clamped decrement
module coin_inventory #(
    parameter int INV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [INV_W-1:0] load_cnt,
    input  logic             dec,
    output logic [INV_W-1:0] cnt
);
    localparam logic [INV_W:0] ONE = 1;
    logic [INV_W:0] sum, nxt;
    always_comb begin
        sum = {1'b0, cnt} + (load ? {1'b0, load_cnt} : '0);
        nxt = (dec && sum != '0) ? sum - ONE : sum;
    end
    always_ff @(posedge clk)
        cnt <= rst ? '0 : nxt[INV_W] ? '1 : nxt[INV_W-1:0];
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: plans and ejects 5rs/10rs coins one at a time, confirming each via its hopper sensor
module change_dispenser
    import change_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int TIMEOUT      = 16,
    parameter int INV_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [1:0]       req_amt,
    output logic             req_ready,
    output logic             eject5,
    output logic             eject10,
    input  logic             sense5,
    input  logic             sense10,
    input  logic             load_valid,
    input  logic             load_sel,
    input  logic [INV_W-1:0] load_cnt,
    output logic [INV_W-1:0] inv5,
    output logic [INV_W-1:0] inv10,
    output logic             done,
    input  logic             fault_clr,
    output logic [1:0]       fault
);
    localparam int CMAX = PULSE_CYCLES > TIMEOUT ? PULSE_CYCLES : TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);
    state_e        state;
    amt_e          amt;
    logic [CW-1:0] cnt;
    logic          n10;
    logic [1:0]    n5;
    logic [1:0]    avail5;
    plan_t         plan;
    logic          hit, last;
    always_comb begin
        avail5 = inv5 > INV_W'(3) ? 2'd3 : inv5[1:0];
        plan   = make_plan(amt, inv10 != '0, avail5);
        hit    = state == WAIT && (n10 ? sense10 : sense5);
        last   = n10 ? n5 == 2'd0 : n5 == 2'd1;
    end
    assign req_ready = state == IDLE;
    coin_inventory #(.INV_W(INV_W)) u_inv5 (
        .clk(clk), .rst(rst), .load(load_valid && !load_sel), .load_cnt(load_cnt),
        .dec(hit && !n10), .cnt(inv5)
    );
    coin_inventory #(.INV_W(INV_W)) u_inv10 (
        .clk(clk), .rst(rst), .load(load_valid && load_sel), .load_cnt(load_cnt),
        .dec(hit && n10), .cnt(inv10)
    );
    // cnt times the eject pulse in EJECT and the sensor timeout in WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            amt     <= AMT_0;
            cnt     <= '0;
            n10     <= 1'b0;
            n5      <= 2'd0;
            eject5  <= 1'b0;
            eject10 <= 1'b0;
            done    <= 1'b0;
            fault   <= FAULT_NONE;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    amt   <= amt_e'(req_amt);
                    state <= PLAN;
                end
                PLAN: if (!plan.ok) begin
                    fault <= FAULT_NOCOIN;
                    state <= FAULT;
                end else if (amt == AMT_0) begin
                    done  <= 1'b1;
                    state <= DONE;
                end else begin
                    n10     <= plan.n10;
                    n5      <= plan.n5;
                    eject10 <= plan.n10;
                    eject5  <= !plan.n10;
                    cnt     <= CW'(PULSE_CYCLES - 1);
                    state   <= EJECT;
                end
                EJECT: if (cnt == '0) begin
                    eject5  <= 1'b0;
                    eject10 <= 1'b0;
                    cnt     <= CW'(TIMEOUT - 1);
                    state   <= WAIT;
                end else
                    cnt <= cnt - CW'(1);
                WAIT: if (hit) begin
                    if (n10) n10 <= 1'b0;
                    else n5 <= n5 - 2'd1;
                    if (last) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        eject5 <= 1'b1;
                        cnt    <= CW'(PULSE_CYCLES - 1);
                        state  <= EJECT;
                    end
                end else if (cnt == '0) begin
                    fault <= FAULT_TIMEOUT;
                    state <= FAULT;
                end else
                    cnt <= cnt - CW'(1);
                DONE: state <= IDLE;
                FAULT: if (fault_clr) begin
                    fault <= FAULT_NONE;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
